// File: rtl/nn_neuron_mac.sv
// Single-neuron evaluator: serial single-precision MAC over N_INPUTS samples, bias add, then activation.
// Optional macro NN_LEAKY_RELU_EN enables leaky ReLU for act_mode 2'b10 (otherwise that mode is plain ReLU).
module nn_neuron_mac #(
    parameter int N_INPUTS   = 6,
    parameter int AW         = $clog2(N_INPUTS + 1),
    parameter int LEAK_SHIFT = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          start,
    input  logic [1:0]    act_mode,
    input  logic          x_valid,
    input  logic [31:0]   x_data,
    output logic          x_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out,
    output logic          eoc,
    output logic          busy
);

    generate
        if (N_INPUTS < 2 || N_INPUTS > 64 || LEAK_SHIFT < 1 || LEAK_SHIFT > 7) begin : g_param_check
            $error("nn_neuron_mac: parameter out of range");
        end
    endgenerate

    localparam logic [AW-1:0] LAST_IDX  = AW'(N_INPUTS - 1);
    localparam logic [AW-1:0] BIAS_ADDR = AW'(N_INPUTS);
`ifdef NN_LEAKY_RELU_EN
    localparam logic [7:0]    LEAK_E    = 8'(LEAK_SHIFT);
`endif

    typedef enum logic [2:0] {IDLE, ACCUM, BIAS, ACT, DONE} state_t;

    state_t        state, state_next;
    logic [31:0]   acc, acc_next;
    logic [AW-1:0] idx, idx_next;
    logic [1:0]    mode, mode_next;
    logic [31:0]   out_next;
    logic          out_valid_next;
    logic          eoc_next;
    logic [31:0]   w [0:N_INPUTS];
    logic [31:0]   prod, addend, sum;

    // Round-to-nearest-even and pack; sig carries the leading one in bit 23.
    function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                            input logic [23:0] sig, input logic g, input logic st);
        logic              rnd;
        logic [24:0]       mr;
        logic signed [9:0] e2;
        logic [22:0]       m;
        logic [31:0]       res;
        rnd = g & (st | sig[0]);
        mr  = {1'b0, sig} + {24'b0, rnd};
        if (mr[24]) begin
            e2 = e + 10'sd1;
            m  = mr[23:1];
        end else begin
            e2 = e;
            m  = mr[22:0];
        end
        if (e2 >= 10'sd255)
            res = {s, 8'hFF, 23'b0};
        else if (e2 <= 10'sd0)
            res = {s, 31'b0};
        else
            res = {s, e2[7:0], m};
        return res;
    endfunction

    // Denormal operands are treated as zero; results that would be denormal flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        logic [47:0]       p;
        logic signed [9:0] e;
        logic [31:0]       res;
        s = a[31] ^ b[31];
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
            res = 32'h7FC0_0000;
        else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
            res = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? 32'h7FC0_0000 : {s, 8'hFF, 23'b0};
        else if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
            res = {s, 31'b0};
        else if (p[47])
            res = fp_pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
        else
            res = fp_pack(s, e, p[46:23], p[22], |p[21:0]);
        return res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       x, y;
        logic [7:0]        d8;
        logic [5:0]        sh;
        logic [26:0]       mx, my, r;
        logic [53:0]       al;
        logic [27:0]       sm;
        logic signed [9:0] e;
        logic [31:0]       res;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d8 = x[30:23] - y[30:23];
        sh = (d8 > 8'd27) ? 6'd27 : d8[5:0];
        mx = {1'b1, x[22:0], 3'b000};
        al = {1'b1, y[22:0], 3'b000, 27'b0} >> sh;
        // Bits shifted past the round position collapse into a sticky bit.
        my = {al[53:28], al[27] | (|al[26:0])};
        e  = $signed({2'b00, x[30:23]});
        sm = '0;
        r  = '0;
        if (x[31] == y[31]) begin
            sm = {1'b0, mx} + {1'b0, my};
            if (sm[27]) begin
                r = {sm[27:2], sm[1] | sm[0]};
                e = e + 10'sd1;
            end else begin
                r = sm[26:0];
            end
        end else begin
            r = mx - my;
            for (int unsigned i = 0; i < 26; i++) begin
                if (!r[26] && r != '0) begin
                    r = {r[25:0], 1'b0};
                    e = e - 10'sd1;
                end
            end
        end
        if ((a[30:23] == 8'hFF && a[22:0] != '0) || (b[30:23] == 8'hFF && b[22:0] != '0))
            res = 32'h7FC0_0000;
        else if (a[30:23] == 8'hFF)
            res = (b[30:23] == 8'hFF && a[31] != b[31]) ? 32'h7FC0_0000 : a;
        else if (b[30:23] == 8'hFF)
            res = b;
        else if (a[30:23] == 8'h00 && b[30:23] == 8'h00)
            res = {a[31] & b[31], 31'b0};
        else if (a[30:23] == 8'h00)
            res = b;
        else if (b[30:23] == 8'h00)
            res = a;
        else if (r == '0)
            res = 32'h0;
        else
            res = fp_pack(x[31], e, r[26:3], r[2], |r[1:0]);
        return res;
    endfunction

    function automatic logic [31:0] activate(input logic [31:0] v, input logic [1:0] m);
        logic [31:0] res;
        res = v[31] ? 32'h0 : v;
        case (m)
            2'b00: res = v;
`ifdef NN_LEAKY_RELU_EN
            2'b10: begin
                if (!v[31])
                    res = v;
                else if (v[30:23] <= LEAK_E)
                    res = 32'h8000_0000;
                else
                    res = {1'b1, v[30:23] - LEAK_E, v[22:0]};
            end
`endif
            default: res = v[31] ? 32'h0 : v;
        endcase
        return res;
    endfunction

    // Weight/bias store: plain registers, deliberately not reset so weights survive an abort.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE || state == DONE) && wr_addr <= BIAS_ADDR)
            w[wr_addr] <= wr_data;
    end

    // One shared adder: MAC term while accumulating, bias word in BIAS.
    always_comb begin
        prod   = fp_mul(x_data, w[idx]);
        addend = (state == BIAS) ? w[BIAS_ADDR] : prod;
        sum    = fp_add(acc, addend);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            mode      <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            eoc       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            idx       <= idx_next;
            mode      <= mode_next;
            out       <= out_next;
            out_valid <= out_valid_next;
            eoc       <= eoc_next;
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        idx_next       = idx;
        mode_next      = mode;
        out_next       = out;
        out_valid_next = out_valid;
        eoc_next       = 1'b0;
        x_ready        = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    acc_next   = '0;
                    idx_next   = '0;
                    mode_next  = act_mode;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                x_ready = 1'b1;
                if (x_valid) begin
                    acc_next = sum;
                    idx_next = idx + 1'b1;
                    if (idx == LAST_IDX)
                        state_next = BIAS;
                end
            end
            BIAS: begin
                acc_next   = sum;
                state_next = ACT;
            end
            ACT: begin
                out_next       = activate(acc, mode);
                out_valid_next = 1'b1;
                eoc_next       = 1'b1;
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed self-checking bench for nn_neuron_mac with N_INPUTS=4, LEAK_SHIFT=3.
module tb_nn_neuron_mac;

    localparam int          N         = 4;
    localparam logic [31:0] ONE       = 32'h3F80_0000;
    localparam logic [31:0] M_ONE     = 32'hBF80_0000;
    localparam logic [31:0] TWO       = 32'h4000_0000;
    localparam logic [31:0] THREE     = 32'h4040_0000;
    localparam logic [31:0] M_SIXTEEN = 32'hC180_0000;
    localparam logic [31:0] JUNK      = 32'h42C8_0000;
    localparam logic [31:0] SEVEN     = 32'h40E0_0000;
    localparam logic [31:0] ELEVEN    = 32'h4130_0000;
    localparam logic [31:0] M_EIGHT   = 32'hC100_0000;
`ifdef NN_LEAKY_RELU_EN
    localparam logic [31:0] EXP_LEAKY = 32'hBF80_0000;
`else
    localparam logic [31:0] EXP_LEAKY = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [1:0]  act_mode;
    logic        x_valid;
    logic [31:0] x_data;
    logic        x_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_w;
    logic        eoc;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    nn_neuron_mac #(.N_INPUTS(N), .LEAK_SHIFT(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .act_mode (act_mode),
        .x_valid  (x_valid),
        .x_data   (x_data),
        .x_ready  (x_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out_w),
        .eoc      (eoc),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic write_w(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] bias);
        for (int i = 0; i < N; i++) write_w(3'(i), ONE);
        write_w(3'd4, bias);
    endtask

    // Runs one evaluation with x_data=2.0 for each accepted sample; leaves the DUT in DONE.
    task automatic run_eval(input logic [1:0] mode, input bit toggle, input int wr_at,
                            output logic [31:0] res, output int edges, output logic eoc_rise,
                            output logic eoc_after, output logic xr_seen, output bit got);
        int sent;
        bit phase;
        sent = 0;
        phase = 1'b0;
        got = 1'b0;
        edges = 0;
        eoc_rise = 1'b0;
        eoc_after = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        act_mode = mode;
        @(negedge clk);
        start   = 1'b0;
        xr_seen = x_ready;
        while (edges < 40 && !got) begin
            if (sent < N && (!toggle || !phase)) begin
                x_valid = 1'b1;
                x_data  = TWO;
                sent++;
            end else begin
                x_valid = 1'b0;
                x_data  = JUNK;
            end
            phase = ~phase;
            if (edges == wr_at) begin
                wr_en   = 1'b1;
                wr_addr = 3'd1;
                wr_data = 32'h4120_0000;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (out_valid) begin
                got      = 1'b1;
                eoc_rise = eoc;
            end
        end
        x_valid = 1'b0;
        wr_en   = 1'b0;
        res     = out_w;
        @(negedge clk);
        eoc_after = eoc;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (out_w !== 32'h0) begin fails++; $display("FAIL reset_out: got %h expected %h", out_w, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (eoc !== 1'b0) begin fails++; $display("FAIL reset_eoc: got %b expected 0", eoc); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (x_ready !== 1'b0) begin fails++; $display("FAIL reset_x_ready: got %b expected 0", x_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_relu_basic();
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        load_weights(M_ONE);
        run_eval(2'b01, 1'b0, -1, res, edges, er, ea, xr, got);
        checks++; if (got !== 1'b1) begin fails++; $display("FAIL basic_timeout: got %b expected 1", got); end
        checks++; if (res !== SEVEN) begin fails++; $display("FAIL basic_out: got %h expected %h", res, SEVEN); end
        checks++; if (edges !== N + 2) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", edges, N + 2); end
        checks++; if (xr !== 1'b1) begin fails++; $display("FAIL basic_x_ready: got %b expected 1", xr); end
        checks++; if (er !== 1'b1) begin fails++; $display("FAIL basic_eoc_rise: got %b expected 1", er); end
        checks++; if (ea !== 1'b0) begin fails++; $display("FAIL basic_eoc_once: got %b expected 0", ea); end
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid_held: got %b expected 1", out_valid); end
        release_out();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy %b expected 0", busy); end
    endtask

    task automatic test_modes();
        logic [1:0]  modes [4];
        logic [31:0] exps  [4];
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        modes = '{2'b01, 2'b00, 2'b10, 2'b11};
        exps  = '{32'h0, M_EIGHT, EXP_LEAKY, 32'h0};
        write_w(3'd4, M_SIXTEEN);
        for (int i = 0; i < 4; i++) begin
            run_eval(modes[i], 1'b0, -1, res, edges, er, ea, xr, got);
            checks++;
            if (!got || res !== exps[i]) begin
                fails++;
                $display("FAIL mode_%b_out: got %h (valid seen %b) expected %h", modes[i], res, got, exps[i]);
            end
            release_out();
        end
        write_w(3'd4, M_ONE);
    endtask

    task automatic test_toggle();
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        run_eval(2'b01, 1'b1, -1, res, edges, er, ea, xr, got);
        checks++; if (!got || res !== SEVEN) begin fails++; $display("FAIL toggle_out: got %h expected %h", res, SEVEN); end
        checks++; if (edges !== N + 5) begin fails++; $display("FAIL toggle_latency: got %0d expected %0d", edges, N + 5); end
        release_out();
    endtask

    task automatic test_done_hold();
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        bit out_stable, valid_stable;
        run_eval(2'b01, 1'b0, -1, res, edges, er, ea, xr, got);
        out_stable   = 1'b1;
        valid_stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            if (i == 6) begin
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = THREE;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            if (out_w !== SEVEN) out_stable = 1'b0;
            if (out_valid !== 1'b1) valid_stable = 1'b0;
        end
        start = 1'b0;
        wr_en = 1'b0;
        checks++; if (out_stable !== 1'b1) begin fails++; $display("FAIL done_out_stable: got %h expected %h", out_w, SEVEN); end
        checks++; if (valid_stable !== 1'b1) begin fails++; $display("FAIL done_valid_stable: got %b expected 1", valid_stable); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if ({busy, out_valid} !== 2'b00) begin fails++; $display("FAIL done_release: got busy,valid %b expected 00", {busy, out_valid}); end
        run_eval(2'b01, 1'b0, -1, res, edges, er, ea, xr, got);
        checks++; if (!got || res !== ELEVEN) begin fails++; $display("FAIL done_write_applied: got %h expected %h", res, ELEVEN); end
        release_out();
        write_w(3'd0, ONE);
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        bit spurious;
        @(negedge clk);
        start    = 1'b1;
        act_mode = 2'b01;
        @(negedge clk);
        start   = 1'b0;
        x_valid = 1'b1;
        x_data  = TWO;
        repeat (2) @(negedge clk);
        x_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checks++;
        if ({busy, x_ready, out_valid, eoc, out_w} !== 36'h0) begin
            fails++;
            $display("FAIL abort_outputs: got busy %b x_ready %b valid %b eoc %b out %h expected all 0",
                     busy, x_ready, out_valid, eoc, out_w);
        end
        spurious = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || eoc) spurious = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || eoc || busy) spurious = 1'b1;
        end
        checks++; if (spurious !== 1'b0) begin fails++; $display("FAIL abort_no_result: got %b expected 0", spurious); end
        run_eval(2'b01, 1'b0, -1, res, edges, er, ea, xr, got);
        checks++; if (!got || res !== SEVEN) begin fails++; $display("FAIL abort_rerun_out: got %h expected %h", res, SEVEN); end
        checks++; if (edges !== N + 2) begin fails++; $display("FAIL abort_rerun_latency: got %0d expected %0d", edges, N + 2); end
        release_out();
    endtask

    task automatic test_wr_during_accum();
        logic [31:0] res;
        int edges;
        logic er, ea, xr;
        bit got;
        run_eval(2'b01, 1'b0, 1, res, edges, er, ea, xr, got);
        checks++; if (!got || res !== SEVEN) begin fails++; $display("FAIL accum_wr_out: got %h expected %h", res, SEVEN); end
        release_out();
        run_eval(2'b01, 1'b0, -1, res, edges, er, ea, xr, got);
        checks++; if (!got || res !== SEVEN) begin fails++; $display("FAIL accum_wr_retained: got %h expected %h", res, SEVEN); end
        release_out();
    endtask

    initial begin
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        act_mode  = 2'b00;
        x_valid   = 1'b0;
        x_data    = '0;
        out_ready = 1'b0;
        test_reset();
        test_relu_basic();
        test_modes();
        test_toggle();
        test_done_hold();
        test_reset_abort();
        test_wr_during_accum();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nn_neuron_mac.md
NN_NEURON_MAC -- requirements
Module: nn_neuron_mac

Interface
REQ-001 SHALL have parameter N_INPUTS, default 6: inputs per neuron (2..64).
REQ-002 SHALL have parameter AW, default $clog2(N_INPUTS+1): weight/bias memory address width.
REQ-003 SHALL have parameter LEAK_SHIFT, default 3: leaky-ReLU slope 2^-LEAK_SHIFT (1..7).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  write strobe for the weight/bias memory.
REQ-007 wr_addr  in  AW  address 0..N_INPUTS-1 = weights; N_INPUTS = bias.
REQ-008 wr_data  in  32  IEEE-754 single-precision word to write.
REQ-009 start  in  1  begin one neuron evaluation.
REQ-010 act_mode  in  2  00 identity, 01 ReLU, 10 leaky ReLU, 11 ReLU; sampled with start.
REQ-011 x_valid  in  1  x_data valid.
REQ-012 x_data  in  32  IEEE-754 input sample.
REQ-013 x_ready  out  1  block accepts x_data this cycle.
REQ-014 out_valid  out  1  result valid; held until out_ready.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 out  out  32  IEEE-754 activated result.
REQ-017 eoc  out  1  one-cycle pulse when out_valid first rises.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, ACCUM, BIAS, ACT, DONE; single-precision multiply and add are combinational, one op per state cycle.
REQ-020 IDLE: start=1 -> acc<=+0.0, idx<=0, mode latched, go ACCUM; start in any other state is ignored.
REQ-021 ACCUM: x_ready=1; on x_valid&x_ready acc<=acc+x_data*w[idx], idx<=idx+1; no x_valid -> hold acc, idx.
REQ-022 ACCUM -> BIAS on acceptance with idx=N_INPUTS-1.
REQ-023 BIAS: acc<=acc+w[N_INPUTS]; go ACT.
REQ-024 ACT: out<=f(acc), out_valid<=1, eoc<=1 for this edge only; go DONE.
REQ-025 f identity: out=acc; ReLU: out=acc if sign=0 else 32'h0 (including -0.0 -> +0.0).
REQ-026 Leaky: sign=0 -> acc; sign=1 -> exponent reduced by LEAK_SHIFT, mantissa/sign kept; exponent <= LEAK_SHIFT -> 32'h8000_0000.
REQ-027 DONE: out and out_valid held; out_ready=1 -> out_valid<=0, go IDLE; start in DONE ignored.
REQ-028 Latency with x_valid held high: out_valid rises N_INPUTS+2 edges after the edge sampling start.
REQ-029 wr_en honoured only in IDLE or DONE; ignored when busy in ACCUM/BIAS/ACT; wr_addr>N_INPUTS ignored.
REQ-030 x_ready=0 outside ACCUM; x_valid outside ACCUM is dropped.
REQ-031 Weight memory is registers, not reset, read asynchronously by idx.

Reset
REQ-032 rst_n=0 -> state IDLE, acc=0, idx=0, out=32'h0, out_valid=0, eoc=0, x_ready=0, busy=0, immediately and regardless of clk.
REQ-033 Reset mid-evaluation aborts it; no out_valid or eoc is produced for the aborted run; weight contents are retained.

Configuration
REQ-034 Macro NN_LEAKY_RELU_EN defined: act_mode 10 is leaky ReLU per REQ-026.
REQ-035 NN_LEAKY_RELU_EN undefined: leaky logic is absent; act_mode 10 behaves as ReLU; LEAK_SHIFT is unused.

Verification (N_INPUTS=4)
REQ-036 Weights 4x 0x3F800000, bias 0xBF800000; x=0x40000000 x4, ReLU -> out=0x40E00000 (7.0) at 6th edge after start; eoc pulses once.
REQ-037 Same weights, bias 0xC1800000 (-16.0), ReLU -> out=0x00000000; identity -> 0xC1000000; leaky with LEAK_SHIFT=3 and macro -> 0xBF800000 (-1.0); without macro -> 0x00000000.
REQ-038 x_valid toggled 1,0,1,0... -> same 0x40E00000 result, out_valid delayed by 3 edges, x_data with x_valid=0 is not accumulated.
REQ-039 out_ready held low 10 cycles -> out and out_valid stable; start and wr_en pulses during DONE do not change out; out_ready=1 -> IDLE next edge.
REQ-040 rst_n low during ACCUM after 2 samples -> all outputs 0 at once; new start with 4 samples -> correct 0x40E00000 with stored weights.
REQ-041 wr_en to address 1 during ACCUM -> ignored; result equals REQ-036 value.
